// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with majority voting, parity and stop-bit checks
//
// Ports:
//   i_Clock, i_Rst_L      clock and asynchronous active-low reset
//   i_RX_Serial           asynchronous serial line, idle high
//   i_Clks_Per_Bit        clocks per bit cell, latched at start of frame
//   i_Parity_En/_Odd      parity enable and odd/even select, latched at start of frame
//   i_Two_Stop            two stop bits checked, latched at start of frame
//   o_RX_DV               one-cycle frame-complete strobe
//   o_RX_Data             received data word, LSB first on the line
//   o_Parity_Err/_Frame_Err/_Break   frame status, updated with o_RX_DV
//   o_Busy                high whenever the receiver is not idle
module uart_rx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_Serial,
    input  logic [DIV_W-1:0]     i_Clks_Per_Bit,
    input  logic                 i_Parity_En,
    input  logic                 i_Parity_Odd,
    input  logic                 i_Two_Stop,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
    } state_t;

    state_t               state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DIV_W-1:0]     cnt_q;
    logic [DIV_W-1:0]     div_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 par_en_q, par_odd_q, two_stop_q;
    logic                 s0_q, s1_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bit_q;
    logic                 ferr_q;
    logic                 stop1_low_q;

    logic                 rx_s;
    logic [DIV_W-1:0]     half_d;
    logic                 samp0_d, samp1_d, dec_d, cell_end_d;
    logic                 maj_d;
    logic                 last_stop_d;
    logic                 frame_err_d;
    logic                 first_stop_low_d;
    logic [DIV_W-1:0]     cnt_inc_d;

    // Synchronizer resets to the idle-high line level so reset release never looks like a start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_RX_Serial};
        end
    end

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign half_d     = div_q >> 1;
    assign samp0_d    = (cnt_q == half_d - 1'b1);
    assign samp1_d    = (cnt_q == half_d);
    assign dec_d      = (cnt_q == half_d + 1'b1);
    assign cell_end_d = (cnt_q == div_q - 1'b1);
    assign cnt_inc_d  = cell_end_d ? '0 : cnt_q + 1'b1;
    // Third sample is taken live at the decision point.
    assign maj_d      = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    // Final stop decision: cell 1 in one-stop mode, cell 2 in two-stop mode.
    assign last_stop_d      = !two_stop_q || (bit_idx_q == IDX_W'(1));
    assign frame_err_d      = ferr_q | ~maj_d;
    assign first_stop_low_d = (bit_idx_q == '0) ? ~maj_d : stop1_low_q;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            bit_idx_q    <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            two_stop_q   <= 1'b0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            ferr_q       <= 1'b0;
            stop1_low_q  <= 1'b0;
            o_RX_DV      <= 1'b0;
            o_RX_Data    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            if (samp0_d) s0_q <= rx_s;
            if (samp1_d) s1_q <= rx_s;

            case (state_q)
                ST_IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (!rx_s) begin
                        // The detection cycle counts as cnt = 0 of the start cell.
                        state_q     <= ST_START;
                        cnt_q       <= DIV_W'(1);
                        div_q       <= i_Clks_Per_Bit;
                        par_en_q    <= i_Parity_En;
                        par_odd_q   <= i_Parity_Odd;
                        two_stop_q  <= i_Two_Stop;
                        ferr_q      <= 1'b0;
                        stop1_low_q <= 1'b0;
                    end
                end
                ST_START: begin
                    cnt_q <= cnt_inc_d;
                    if (dec_d && maj_d) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cell_end_d) begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                    end
                end
                ST_DATA: begin
                    cnt_q <= cnt_inc_d;
                    if (dec_d) shift_q <= {maj_d, shift_q[DATA_BITS-1:1]};
                    if (cell_end_d) begin
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx_q <= '0;
                            state_q   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    cnt_q <= cnt_inc_d;
                    if (dec_d) par_bit_q <= maj_d;
                    if (cell_end_d) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    cnt_q <= cnt_inc_d;
                    if (dec_d) begin
                        ferr_q <= frame_err_d;
                        if (bit_idx_q == '0) stop1_low_q <= ~maj_d;
                        if (last_stop_d) begin
                            // Finish without waiting for the end of the stop cell.
                            o_RX_DV      <= 1'b1;
                            o_RX_Data    <= shift_q;
                            o_Parity_Err <= par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);
                            o_Frame_Err  <= frame_err_d;
                            o_Break      <= (shift_q == '0) & (~par_en_q | ~par_bit_q) & first_stop_low_d;
                            state_q      <= frame_err_d ? ST_WAIT_HIGH : ST_IDLE;
                            cnt_q        <= '0;
                            bit_idx_q    <= '0;
                        end
                    end else if (cell_end_d) begin
                        bit_idx_q <= IDX_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // A stuck-low line reports once, then waits here for the line to recover.
                    cnt_q <= '0;
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_Busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [15:0] cpb;
    logic        par_en, par_odd, two_stop;
    logic        o_RX_DV;
    logic [7:0]  o_RX_Data;
    logic        o_Parity_Err, o_Frame_Err, o_Break, o_Busy;

    int checks = 0;
    int errors = 0;
    int dv_count = 0;
    logic [7:0] cap_data = 8'h00;
    logic [2:0] cap_flags = 3'b000;    // {parity, frame, break}
    logic [7:0] data_log[$];

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_BITS(8), .DIV_W(16), .SYNC_STAGES(2)) dut (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx), .i_Clks_Per_Bit(cpb),
        .i_Parity_En(par_en), .i_Parity_Odd(par_odd), .i_Two_Stop(two_stop),
        .o_RX_DV(o_RX_DV), .o_RX_Data(o_RX_Data), .o_Parity_Err(o_Parity_Err),
        .o_Frame_Err(o_Frame_Err), .o_Break(o_Break), .o_Busy(o_Busy)
    );

    always @(negedge clk) begin
        if (o_RX_DV === 1'b1) begin
            dv_count++;
            cap_data  = o_RX_Data;
            cap_flags = {o_Parity_Err, o_Frame_Err, o_Break};
            data_log.push_back(o_RX_Data);
        end
    end

    task automatic align();
        @(posedge clk);
        #3;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit pen, input bit pbit,
                              input bit stop1, input bit stop2, input bit two,
                              input int bit_ns, input int glitch_bit);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (i == glitch_bit) begin
                #(bit_ns / 2 + 5);
                rx = 1'b0;
                #10;
                rx = 1'b1;
                #(bit_ns - bit_ns / 2 - 15);
            end else begin
                #(bit_ns);
            end
        end
        if (pen) begin
            rx = pbit;
            #(bit_ns);
        end
        rx = stop1;
        #(bit_ns);
        if (two) begin
            rx = stop2;
            #(bit_ns);
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx = 1'b1; cpb = 16'd16; par_en = 0; par_odd = 0; two_stop = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_RX_DV, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {o_RX_DV, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Busy});
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_8n1();
        int n0;
        cpb = 16'd16; par_en = 0; two_stop = 0;
        align(); n0 = dv_count;
        send_frame(8'hA5, 0, 0, 1, 1, 0, 160, -1);
        #320; @(negedge clk);
        checks++; if (dv_count - n0 !== 1) begin errors++; $display("FAIL 8n1_pulses: got %0d expected 1", dv_count - n0); end
        checks++; if (cap_data !== 8'hA5) begin errors++; $display("FAIL 8n1_data: got %h expected a5", cap_data); end
        checks++; if (cap_flags !== 3'b000) begin errors++; $display("FAIL 8n1_flags: got %b expected 000", cap_flags); end
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy: got %b expected 0", o_Busy); end
    endtask

    task automatic test_parity();
        int n0;
        cpb = 16'd16; par_en = 1; par_odd = 0; two_stop = 0;
        align(); n0 = dv_count;
        send_frame(8'h03, 1, 1, 1, 1, 0, 160, -1);
        #320; @(negedge clk);
        checks++; if (dv_count - n0 !== 1) begin errors++; $display("FAIL par_bad_pulses: got %0d expected 1", dv_count - n0); end
        checks++; if (cap_data !== 8'h03) begin errors++; $display("FAIL par_bad_data: got %h expected 03", cap_data); end
        checks++; if (cap_flags !== 3'b100) begin errors++; $display("FAIL par_bad_flags: got %b expected 100", cap_flags); end
        align();
        send_frame(8'h03, 1, 0, 1, 1, 0, 160, -1);
        #320; @(negedge clk);
        checks++; if (dv_count - n0 !== 2) begin errors++; $display("FAIL par_good_pulses: got %0d expected 2", dv_count - n0); end
        checks++; if (cap_flags !== 3'b000) begin errors++; $display("FAIL par_good_flags: got %b expected 000", cap_flags); end
        par_en = 0;
    endtask

    task automatic test_glitch();
        int n0;
        cpb = 16'd16; par_en = 0; two_stop = 0;
        align(); n0 = dv_count;
        rx = 1'b0; #30; rx = 1'b1;
        #14;
        checks++; if (o_Busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", o_Busy); end
        #466; @(negedge clk);
        checks++; if (dv_count - n0 !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", dv_count - n0); end
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", o_Busy); end
        align();
        send_frame(8'hFF, 0, 0, 1, 1, 0, 160, 2);
        #320; @(negedge clk);
        checks++; if (dv_count - n0 !== 1) begin errors++; $display("FAIL vote_pulses: got %0d expected 1", dv_count - n0); end
        checks++; if (cap_data !== 8'hFF) begin errors++; $display("FAIL vote_data: got %h expected ff", cap_data); end
    endtask

    task automatic test_stop_break();
        int n0;
        cpb = 16'd16; par_en = 0; two_stop = 1;
        align(); n0 = dv_count;
        send_frame(8'h5A, 0, 0, 1, 0, 1, 160, -1);
        #320; @(negedge clk);
        checks++; if (dv_count - n0 !== 1) begin errors++; $display("FAIL stop2_pulses: got %0d expected 1", dv_count - n0); end
        checks++; if (cap_data !== 8'h5A) begin errors++; $display("FAIL stop2_data: got %h expected 5a", cap_data); end
        checks++; if (cap_flags !== 3'b010) begin errors++; $display("FAIL stop2_flags: got %b expected 010", cap_flags); end
        two_stop = 0;
        align(); n0 = dv_count;
        rx = 1'b0;
        #(15 * 160); @(negedge clk);
        checks++; if (dv_count - n0 !== 1) begin errors++; $display("FAIL break_pulses: got %0d expected 1", dv_count - n0); end
        checks++; if (cap_flags !== 3'b011) begin errors++; $display("FAIL break_flags: got %b expected 011", cap_flags); end
        checks++; if (cap_data !== 8'h00) begin errors++; $display("FAIL break_data: got %h expected 00", cap_data); end
        checks++; if (o_Busy !== 1'b1) begin errors++; $display("FAIL break_busy_low: got %b expected 1", o_Busy); end
        #(5 * 160);
        rx = 1'b1;
        #320; @(negedge clk);
        checks++; if (dv_count - n0 !== 1) begin errors++; $display("FAIL break_single: got %0d expected 1", dv_count - n0); end
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL break_recover: got %b expected 0", o_Busy); end
        align();
        send_frame(8'h81, 0, 0, 1, 1, 0, 160, -1);
        #320; @(negedge clk);
        checks++; if (dv_count - n0 !== 2) begin errors++; $display("FAIL after_break_pulses: got %0d expected 2", dv_count - n0); end
        checks++; if ({cap_data, cap_flags} !== {8'h81, 3'b000}) begin errors++; $display("FAIL after_break_frame: got %h/%b expected 81/000", cap_data, cap_flags); end
    endtask

    task automatic test_back_to_back();
        int n0;
        int rates[2] = '{100, 97};
        cpb = 16'd10; par_en = 0; two_stop = 0;
        foreach (rates[r]) begin
            align(); n0 = dv_count;
            send_frame(8'h00, 0, 0, 1, 1, 0, rates[r], -1);
            send_frame(8'hFF, 0, 0, 1, 1, 0, rates[r], -1);
            #200; @(negedge clk);
            checks++;
            if (dv_count - n0 !== 2) begin
                errors++; $display("FAIL b2b_pulses_%0d: got %0d expected 2", rates[r], dv_count - n0);
            end else begin
                checks++;
                if ({data_log[n0], data_log[n0 + 1]} !== 16'h00FF) begin
                    errors++; $display("FAIL b2b_data_%0d: got %h %h expected 00 ff", rates[r], data_log[n0], data_log[n0 + 1]);
                end
            end
            checks++; if (cap_flags !== 3'b000) begin errors++; $display("FAIL b2b_flags_%0d: got %b expected 000", rates[r], cap_flags); end
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        cpb = 16'd16; par_en = 0; two_stop = 0;
        align(); n0 = dv_count;
        fork
            send_frame(8'h3C, 0, 0, 1, 1, 0, 160, -1);
            begin
                #(5 * 160 + 80);
                rst_n = 1'b0;
                #1;
                checks++;
                if ({o_RX_DV, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Busy} !== 13'h0) begin
                    errors++;
                    $display("FAIL midreset_outputs: got %h expected 0", {o_RX_DV, o_RX_Data, o_Parity_Err, o_Frame_Err, o_Break, o_Busy});
                end
            end
        join
        #100; rst_n = 1'b1;
        #320; @(negedge clk);
        checks++; if (dv_count - n0 !== 0) begin errors++; $display("FAIL midreset_pulses: got %0d expected 0", dv_count - n0); end
        align();
        send_frame(8'h3C, 0, 0, 1, 1, 0, 160, -1);
        #320; @(negedge clk);
        checks++; if (dv_count - n0 !== 1) begin errors++; $display("FAIL post_reset_pulses: got %0d expected 1", dv_count - n0); end
        checks++; if ({cap_data, cap_flags} !== {8'h3C, 3'b000}) begin errors++; $display("FAIL post_reset_frame: got %h/%b expected 3c/000", cap_data, cap_flags); end
        align();
        fork
            send_frame(8'hC3, 0, 0, 1, 1, 0, 160, -1);
            begin
                #(3 * 160 + 20);
                cpb = 16'd10;
            end
        join
        #320; @(negedge clk);
        cpb = 16'd16;
        checks++; if (dv_count - n0 !== 2) begin errors++; $display("FAIL divchange_pulses: got %0d expected 2", dv_count - n0); end
        checks++; if ({cap_data, cap_flags} !== {8'hC3, 3'b000}) begin errors++; $display("FAIL divchange_frame: got %h/%b expected c3/000", cap_data, cap_flags); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_stop_break();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
